// File: rtl/program_loader.sv
// Boot-time program loader: receives a framed byte stream (length, data, checksum),
// writes the image into RAM from address 0 and releases the CPU after a verified load.
module program_loader #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int RESET_HOLD = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic                  cpu_reset,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      DATA,
      CSUM,
      HOLD,
      RUN,
      ERR
   } state_t;

   localparam int CNT_W = ADDR_WIDTH + 1;

   // A length byte of zero encodes a full 2^ADDR_WIDTH image, hence the extra bit.
   localparam logic [CNT_W-1:0]      FULL_IMAGE = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [CNT_W-1:0]      REM_ONE    = CNT_W'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
   localparam logic [7:0]            HOLD_INIT  = 8'(RESET_HOLD);
   localparam logic [7:0]            HOLD_ONE   = 8'd1;

   state_t                  state;
   state_t                  state_next;
   logic [ADDR_WIDTH-1:0]   pointer;
   logic [CNT_W-1:0]        remaining;
   logic [CNT_W-1:0]        len_value;
   logic [DATA_WIDTH-1:0]   sum;
   logic [7:0]              hold_cnt;
   logic                    beat;
   logic                    sum_ok;

   // Status outputs are pure state decodes, so they change together with the state.
   always_comb begin
      in_ready  = (state == LEN) || (state == DATA) || (state == CSUM);
      busy      = in_ready || (state == HOLD);
      done      = (state == RUN);
      error     = (state == ERR);
      cpu_reset = (state != RUN);
   end

   assign beat   = in_valid && in_ready;
   assign sum_ok = (in_data == sum);

   always_comb begin
      len_value = CNT_W'(in_data);
      if (in_data == '0) begin
         len_value = FULL_IMAGE;
      end
   end

   // NOTE: every signal assigned in a combinational block gets a default first;
   // a path that leaves it unassigned would infer a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE, RUN, ERR: begin
            if (start) begin
               state_next = LEN;
            end
         end
         LEN: begin
            if (beat) begin
               state_next = DATA;
            end
         end
         DATA: begin
            if (beat && (remaining == REM_ONE)) begin
               state_next = CSUM;
            end
         end
         CSUM: begin
            if (beat) begin
               state_next = sum_ok ? HOLD : ERR;
            end
         end
         HOLD: begin
            if (hold_cnt == '0) begin
               state_next = RUN;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Write strobe is a one-cycle pulse per data beat; address and data hold otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_data  <= '0;
         pointer   <= '0;
         remaining <= '0;
         sum       <= '0;
         hold_cnt  <= '0;
      end else begin
         ram_we <= 1'b0;
         unique case (state)
            IDLE, RUN, ERR: begin
               if (start) begin
                  pointer   <= '0;
                  sum       <= '0;
                  remaining <= '0;
                  hold_cnt  <= '0;
               end
            end
            LEN: begin
               if (beat) begin
                  remaining <= len_value;
               end
            end
            DATA: begin
               if (beat) begin
                  ram_we    <= 1'b1;
                  ram_addr  <= pointer;
                  ram_data  <= in_data;
                  pointer   <= pointer + PTR_ONE;
                  sum       <= sum + in_data;
                  remaining <= remaining - REM_ONE;
               end
            end
            CSUM: begin
               if (beat && sum_ok) begin
                  hold_cnt <= HOLD_INIT;
               end
            end
            HOLD: begin
               // Counter sits at zero for one cycle before RUN, giving RESET_HOLD+1 cycles.
               if (hold_cnt != '0) begin
                  hold_cnt <= hold_cnt - HOLD_ONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: framed loads, bad checksum, throttled stream,
// full-size image with pointer wrap, and reset in the middle of a load.
module tb_program_loader;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       ram_we;
   logic [7:0] ram_addr;
   logic [7:0] ram_data;
   logic       cpu_reset;
   logic       busy;
   logic       done;
   logic       error;

   int vectors     = 0;
   int miscompares = 0;

   logic [15:0] wr_q[$];

   program_loader #(
      .ADDR_WIDTH(8),
      .DATA_WIDTH(8),
      .RESET_HOLD(4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_data (ram_data),
      .cpu_reset(cpu_reset),
      .busy     (busy),
      .done     (done),
      .error    (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Log every RAM write, sampled mid-cycle.
   always @(negedge clk) begin
      if (ram_we === 1'b1) begin
         wr_q.push_back({ram_addr, ram_data});
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Present one data byte with valid high and expect its write on the next cycle.
   task automatic send_write(input string tag, input logic [7:0] d, input logic [7:0] a);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      check(tag, {ram_we, ram_addr, ram_data}, {1'b1, a, d});
   endtask

   // Called right after the checksum beat edge: cpu_reset must fall on the 5th edge.
   task automatic check_release(input string tag);
      for (int k = 1; k <= 5; k++) begin
         tick();
         check(tag, {cpu_reset, ram_we}, (k == 5) ? 2'b00 : 2'b10);
      end
      check({tag, "_final"}, {done, busy, error, in_ready}, 4'b1000);
   endtask

   initial begin
      int bad;
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h00;

      // Reset held with in_valid high.
      for (int i = 0; i < 10; i++) begin
         tick();
         check("reset_hold", {cpu_reset, in_ready, ram_we, done, error, busy}, 6'b100000);
      end
      reset    = 1'b0;
      in_valid = 1'b0;
      tick();
      check("idle", {cpu_reset, in_ready, busy, done, error}, 5'b10000);

      // Good frame 03,11,22,33,66 with valid held high.
      pulse_start();
      check("len_state", {in_ready, busy, cpu_reset}, 3'b111);
      wr_q.delete();
      in_valid = 1'b1;
      in_data  = 8'h03;
      tick();
      check("len_no_write", ram_we, 1'b0);
      send_write("f1_w0", 8'h11, 8'h00);
      send_write("f1_w1", 8'h22, 8'h01);
      send_write("f1_w2", 8'h33, 8'h02);
      in_data = 8'h66;
      tick();
      check("f1_csum", {ram_we, busy, in_ready, cpu_reset}, 4'b0101);
      check_release("f1_release");
      // Valid stays high in RUN: nothing consumed, nothing written.
      tick();
      tick();
      check("run_ignore", {done, ram_we, in_ready}, 3'b100);
      in_valid = 1'b0;
      check("f1_count", wr_q.size(), 3);

      // Same frame, bad checksum 67.
      pulse_start();
      check("restart_clears_done", {done, cpu_reset, busy}, 3'b011);
      in_valid = 1'b1;
      in_data  = 8'h03; tick();
      in_data  = 8'h11; tick();
      in_data  = 8'h22; tick();
      in_data  = 8'h33; tick();
      in_data  = 8'h67; tick();
      in_valid = 1'b0;
      check("bad_csum", {error, cpu_reset, done, busy}, 4'b1100);
      for (int i = 0; i < 6; i++) tick();
      check("err_sticky", {error, cpu_reset, done, in_ready}, 4'b1100);
      pulse_start();
      check("err_restart", {error, in_ready, busy, cpu_reset}, 4'b0111);

      // Throttled frame 02,AA,BB,65 with valid toggling each cycle.
      wr_q.delete();
      in_valid = 1'b1; in_data = 8'h02; tick();
      in_valid = 1'b0; tick();
      check("tog_gap0", ram_we, 1'b0);
      send_write("tog_w0", 8'hAA, 8'h00);
      in_valid = 1'b0; tick();
      check("tog_gap1", ram_we, 1'b0);
      send_write("tog_w1", 8'hBB, 8'h01);
      in_valid = 1'b0; tick();
      check("tog_gap2", ram_we, 1'b0);
      in_valid = 1'b1; in_data = 8'h65; tick();
      in_valid = 1'b0;
      check_release("tog_release");
      check("tog_count", wr_q.size(), 2);
      check("tog_log", {wr_q[0], wr_q[1]}, 32'h00AA_01BB);

      // Full 256-byte image, length byte 00, checksum 80.
      pulse_start();
      wr_q.delete();
      in_valid = 1'b1;
      in_data  = 8'h00;
      tick();
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         in_data = 8'(i);
         tick();
         if ({ram_we, ram_addr, ram_data} !== {1'b1, 8'(i), 8'(i)}) bad++;
      end
      check("big_writes_bad", bad, 0);
      check("big_in_csum", {in_ready, busy}, 2'b11);
      in_data = 8'h80;
      tick();
      in_valid = 1'b0;
      check("big_ptr_wrap", dut.pointer, 8'h00);
      check_release("big_release");
      check("big_count", wr_q.size(), 256);

      // Reset in the middle of a load.
      pulse_start();
      wr_q.delete();
      in_valid = 1'b1;
      in_data  = 8'h04; tick();
      send_write("mid_w0", 8'h01, 8'h00);
      send_write("mid_w1", 8'h02, 8'h01);
      reset   = 1'b1;
      in_data = 8'h03;
      tick();
      reset = 1'b0;
      check("mid_reset", {ram_we, cpu_reset, in_ready, busy, done, error}, 6'b010000);
      tick();
      tick();
      check("mid_idle", {ram_we, in_ready, busy, cpu_reset}, 4'b0001);
      in_valid = 1'b0;
      check("mid_count", wr_q.size(), 2);

      // Fresh frame after the aborted one: 02,05,06,0B.
      pulse_start();
      wr_q.delete();
      in_valid = 1'b1;
      in_data  = 8'h02; tick();
      send_write("re_w0", 8'h05, 8'h00);
      send_write("re_w1", 8'h06, 8'h01);
      in_data = 8'h0B; tick();
      in_valid = 1'b0;
      check_release("re_release");
      check("re_count", wr_q.size(), 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
